// File: rtl/univ_shift_reg.sv
// Universal shift register: shift left/right, rotate, parallel load, clear,
// clock enable, and a saturating count of valid bits since reset/load/clear.
module univ_shift_reg #(
  parameter int               WIDTH   = 8,
  parameter logic [WIDTH-1:0] RST_VAL = '0
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       en,
  input  logic [2:0]                 mode,
  input  logic                       sin_r,
  input  logic                       sin_l,
  input  logic [WIDTH-1:0]           pin,
  output logic [WIDTH-1:0]           out,
  output logic                       sout_l,
  output logic                       sout_r,
  output logic [$clog2(WIDTH+1)-1:0] fill_cnt,
  output logic                       full
);

  localparam int               CNT_W   = $clog2(WIDTH + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(WIDTH);

  typedef enum logic [2:0] {
    M_HOLD  = 3'b000,
    M_SHL   = 3'b001,
    M_SHR   = 3'b010,
    M_ROL   = 3'b011,
    M_ROR   = 3'b100,
    M_LOAD  = 3'b101,
    M_CLEAR = 3'b110,
    M_RSVD  = 3'b111
  } mode_e;

  logic [WIDTH-1:0] out_q, out_d;
  logic [CNT_W-1:0] fill_q, fill_d;
  logic             full_q, full_d;

  // Counter never wraps: it sticks at WIDTH once every bit position is valid.
  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] cnt);
    return (cnt >= CNT_MAX) ? CNT_MAX : cnt + CNT_W'(1);
  endfunction

  always_comb begin
    out_d  = out_q;
    fill_d = fill_q;
    if (en) begin
      case (mode_e'(mode))
        M_SHL: begin
          out_d  = {out_q[WIDTH-2:0], sin_r};
          fill_d = sat_inc(fill_q);
        end
        M_SHR: begin
          out_d  = {sin_l, out_q[WIDTH-1:1]};
          fill_d = sat_inc(fill_q);
        end
        M_ROL:   out_d = {out_q[WIDTH-2:0], out_q[WIDTH-1]};
        M_ROR:   out_d = {out_q[0], out_q[WIDTH-1:1]};
        M_LOAD: begin
          out_d  = pin;
          fill_d = CNT_MAX;
        end
        M_CLEAR: begin
          out_d  = RST_VAL;
          fill_d = '0;
        end
        default: ;
      endcase
    end
    // full follows the next-state count so it rises with fill_cnt, not a cycle later
    full_d = (fill_d == CNT_MAX);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      out_q  <= RST_VAL;
      fill_q <= '0;
      full_q <= 1'b0;
    end else begin
      out_q  <= out_d;
      fill_q <= fill_d;
      full_q <= full_d;
    end
  end

  assign out      = out_q;
  assign sout_l   = out_q[WIDTH-1];
  assign sout_r   = out_q[0];
  assign fill_cnt = fill_q;
  assign full     = full_q;

endmodule

// File: tb/tb_univ_shift_reg.sv
// Bench for univ_shift_reg: a 4-bit and an 8-bit instance, a behavioural
// model feeding a scoreboard queue, plus fixed expected values from the test plan.
module tb_univ_shift_reg;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst4, en4, sr4, sl4;
  logic [2:0] mode4;
  logic [3:0] pin4, out4;
  logic       soutl4, soutr4, full4;
  logic [2:0] cnt4;

  logic       rst8, en8, sr8, sl8;
  logic [2:0] mode8;
  logic [7:0] pin8, out8;
  logic       soutl8, soutr8, full8;
  logic [3:0] cnt8;

  univ_shift_reg #(.WIDTH(4), .RST_VAL(4'h0)) dut4 (
    .clk(clk), .rst(rst4), .en(en4), .mode(mode4), .sin_r(sr4), .sin_l(sl4),
    .pin(pin4), .out(out4), .sout_l(soutl4), .sout_r(soutr4),
    .fill_cnt(cnt4), .full(full4)
  );

  univ_shift_reg #(.WIDTH(8), .RST_VAL(8'h00)) dut8 (
    .clk(clk), .rst(rst8), .en(en8), .mode(mode8), .sin_r(sr8), .sin_l(sl8),
    .pin(pin8), .out(out8), .sout_l(soutl8), .sout_r(soutr8),
    .fill_cnt(cnt8), .full(full8)
  );

  localparam logic [2:0] HOLD = 3'd0, SHL = 3'd1, SHR = 3'd2, ROL = 3'd3,
                         ROR = 3'd4, LOAD = 3'd5, CLR = 3'd6, RSVD = 3'd7;

  typedef struct {
    int          which;
    logic [31:0] o;
    int          c;
    logic        f;
  } exp_t;

  exp_t        sb_q[$];
  logic [31:0] m_out [2];
  int          m_cnt [2];
  logic        m_full[2];
  int          n_err = 0;
  int          n_chk = 0;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  // Behavioural next-state model for a register of width w.
  task automatic model(input int which, input logic rst, input logic en, input logic [2:0] mode,
                       input logic sr, input logic sl, input logic [31:0] pin);
    int          w;
    logic [31:0] mask, o;
    int          c;
    w    = (which == 0) ? 4 : 8;
    mask = (32'd1 << w) - 32'd1;
    o    = m_out[which];
    c    = m_cnt[which];
    if (rst) begin
      o = 0; c = 0;
    end else if (en) begin
      case (mode)
        SHL:  begin o = ((o << 1) | 32'(sr)) & mask; c = (c < w) ? c + 1 : w; end
        SHR:  begin o = (o >> 1) | (32'(sl) << (w - 1)); c = (c < w) ? c + 1 : w; end
        ROL:  o = ((o << 1) | (o >> (w - 1))) & mask;
        ROR:  o = (o >> 1) | ((o & 32'd1) << (w - 1));
        LOAD: begin o = pin & mask; c = w; end
        CLR:  begin o = 0; c = 0; end
        default: ;
      endcase
    end
    m_out[which]  = o;
    m_cnt[which]  = c;
    m_full[which] = (c == w);
  endtask

  // One clock: drive the selected instance, hold the other, score after the edge.
  task automatic step(input int which, input logic rst, input logic en, input logic [2:0] mode,
                      input logic sr, input logic sl, input logic [31:0] pin);
    exp_t e;
    rst4 = 0; en4 = 0; mode4 = HOLD; sr4 = 0; sl4 = 0; pin4 = '0;
    rst8 = 0; en8 = 0; mode8 = HOLD; sr8 = 0; sl8 = 0; pin8 = '0;
    if (which == 0) begin
      rst4 = rst; en4 = en; mode4 = mode; sr4 = sr; sl4 = sl; pin4 = pin[3:0];
    end else begin
      rst8 = rst; en8 = en; mode8 = mode; sr8 = sr; sl8 = sl; pin8 = pin[7:0];
    end
    model(which, rst, en, mode, sr, sl, pin);
    e.which = which; e.o = m_out[which]; e.c = m_cnt[which]; e.f = m_full[which];
    sb_q.push_back(e);
    @(posedge clk);
    #1;
    if (sb_q.size() == 0) begin
      check("sb_empty", 32'd0, 32'd1);
    end else begin
      e = sb_q.pop_front();
      if (e.which == 0) begin
        check("sb4_out",  32'(out4),   e.o);
        check("sb4_cnt",  32'(cnt4),   32'(e.c));
        check("sb4_full", 32'(full4),  32'(e.f));
        check("sb4_soutl", 32'(soutl4), 32'(e.o[3]));
        check("sb4_soutr", 32'(soutr4), 32'(e.o[0]));
      end else begin
        check("sb8_out",  32'(out8),   e.o);
        check("sb8_cnt",  32'(cnt8),   32'(e.c));
        check("sb8_full", 32'(full8),  32'(e.f));
        check("sb8_soutl", 32'(soutl8), 32'(e.o[7]));
        check("sb8_soutr", 32'(soutr8), 32'(e.o[0]));
      end
    end
  endtask

  logic [3:0] fill_seq;
  logic [3:0] fill_exp [4];
  logic [7:0] sr_seq;

  initial begin
    m_out[0] = 0; m_cnt[0] = 0; m_full[0] = 0;
    m_out[1] = 0; m_cnt[1] = 0; m_full[1] = 0;
    @(negedge clk);

    // Reset both instances
    step(1, 1, 0, HOLD, 0, 0, 0);
    step(0, 1, 0, HOLD, 0, 0, 0);
    check("rst_out", 32'(out4), 32'h0);
    check("rst_cnt", 32'(cnt4), 32'd0);
    check("rst_full", 32'(full4), 32'd0);

    // Serial fill, 4 bits, then saturate
    fill_seq = 4'b1101;  // sin_r sequence 1,0,1,1 read LSB first
    fill_exp[0] = 4'h1; fill_exp[1] = 4'h2; fill_exp[2] = 4'h5; fill_exp[3] = 4'hB;
    for (int i = 0; i < 4; i++) begin
      step(0, 0, 1, SHL, fill_seq[i], 0, 0);
      check("fill_out", 32'(out4), 32'(fill_exp[i]));
      check("fill_cnt", 32'(cnt4), 32'(i + 1));
    end
    check("fill_full", 32'(full4), 32'd1);
    step(0, 0, 1, SHL, 0, 0, 0);
    check("sat_out", 32'(out4), 32'h6);
    check("sat_cnt", 32'(cnt4), 32'd4);
    check("sat_full", 32'(full4), 32'd1);

    // Reset in the middle of shifting, then resume
    step(0, 0, 1, LOAD, 0, 0, 32'hB);
    step(0, 1, 1, SHL, 1, 0, 0);
    check("mrst_out", 32'(out4), 32'h0);
    check("mrst_cnt", 32'(cnt4), 32'd0);
    check("mrst_full", 32'(full4), 32'd0);
    step(0, 1, 1, SHL, 1, 0, 0);
    step(0, 0, 1, SHL, 1, 0, 0);
    check("resume_out", 32'(out4), 32'h1);
    check("resume_cnt", 32'(cnt4), 32'd1);

    // Enable low, reserved mode, clear
    step(0, 0, 1, LOAD, 0, 0, 32'hB);
    for (int i = 0; i < 3; i++) step(0, 0, 0, SHL, 1, 1, 32'h0);
    check("en0_out", 32'(out4), 32'hB);
    check("en0_cnt", 32'(cnt4), 32'd4);
    step(0, 0, 1, RSVD, 1, 1, 32'h0);
    check("rsvd_out", 32'(out4), 32'hB);
    step(0, 0, 1, CLR, 0, 0, 0);
    check("clr_out", 32'(out4), 32'h0);
    check("clr_cnt", 32'(cnt4), 32'd0);
    check("clr_full", 32'(full4), 32'd0);

    // Mixed directions both count
    step(0, 0, 1, SHL, 1, 0, 0);
    step(0, 0, 1, SHR, 0, 1, 0);
    check("mix_out", 32'(out4), 32'h8);
    check("mix_cnt", 32'(cnt4), 32'd2);

    // Reset beats a simultaneous load
    step(0, 1, 1, LOAD, 0, 0, 32'hF);
    check("simul_out", 32'(out4), 32'h0);
    check("simul_cnt", 32'(cnt4), 32'd0);

    // 8-bit: load then shift right, watching the serial output
    step(1, 0, 1, LOAD, 0, 0, 32'hA5);
    sr_seq = 8'b1010_0101;  // expected sout_r values, index i = before edge i
    for (int i = 0; i < 8; i++) begin
      check("sout_r", 32'(soutr8), 32'(sr_seq[i]));
      step(1, 0, 1, SHR, 0, 0, 0);
      check("shr_cnt", 32'(cnt8), 32'd8);
    end
    check("shr_out", 32'(out8), 32'h00);

    // Rotate
    step(1, 0, 1, LOAD, 0, 0, 32'h81);
    step(1, 0, 1, ROL, 0, 0, 0);
    check("rol_out", 32'(out8), 32'h03);
    step(1, 0, 1, ROR, 0, 0, 0);
    step(1, 0, 1, ROR, 0, 0, 0);
    check("ror_out", 32'(out8), 32'hC0);
    check("rot_cnt", 32'(cnt8), 32'd8);
    check("rot_full", 32'(full8), 32'd1);

    // Random traffic on both widths against the model
    for (int i = 0; i < 200; i++) begin
      step(i % 2, ($urandom_range(0, 19) == 0), ($urandom_range(0, 4) != 0),
           3'($urandom_range(0, 7)), 1'($urandom_range(0, 1)),
           1'($urandom_range(0, 1)), $urandom);
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
